// File: rtl/xpb_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xpb_sched_pkg
//  Description : Shared types and derivation helpers for the XPB reduction
//                lookup sequencer: FSM state encoding, issue-beat count,
//                accumulator width and the beat/lane to table position map.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package xpb_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Number of issue beats needed to cover all digits with the given lanes.
   function automatic int calc_beats(input int num_digits, input int lanes);
      return (num_digits + lanes - 1) / lanes;
   endfunction

   // Width that holds the sum of num_digits values below 2^word_w.
   function automatic int calc_acc_w(input int word_w, input int num_digits);
      return word_w + $clog2(num_digits + 1);
   endfunction

   // Table position serviced by a given lane during a given beat.
   function automatic int lane_pos(input int beat, input int lane, input int lanes);
      return beat * lanes + lane;
   endfunction

endpackage : xpb_sched_pkg
`default_nettype wire

// File: rtl/xpb_lane_acc.sv
`default_nettype none
// ============================================================================
//  Module      : xpb_lane_acc
//  Description : Combinational (LANES+1)-input adder. Adds each returned
//                lookup word (zero-extended, zeroed when its mask bit is low)
//                onto the running accumulator value.
//  Ports       : acc_i   - current accumulator value
//                data_i  - LANES packed WORD_W lookup words
//                mask_i  - per-lane enable; low lanes contribute zero
//                sum_o   - acc_i plus all enabled lane words
//  Revision    : 1.0 - initial release
// ============================================================================
module xpb_lane_acc
   import xpb_sched_pkg::*;
#(
   parameter int WORD_W = 1024,
   parameter int LANES  = 2,
   parameter int ACC_W  = 1028
) (
   input  logic [ACC_W-1:0]        acc_i,
   input  logic [LANES*WORD_W-1:0] data_i,
   input  logic [LANES-1:0]        mask_i,
   output logic [ACC_W-1:0]        sum_o
);

   logic [ACC_W-1:0] w_term [LANES];

   genvar gi;
   for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_term[gi] = mask_i[gi] ? ACC_W'(data_i[gi*WORD_W +: WORD_W]) : '0;
   end

   always_comb begin
      sum_o = acc_i;
      for (int l = 0; l < LANES; l++) begin
         sum_o = sum_o + w_term[l];
      end
   end

endmodule : xpb_lane_acc
`default_nettype wire

// File: rtl/xpb_reduce_sched.sv
`default_nettype none
// ============================================================================
//  Module      : xpb_reduce_sched
//  Description : Time-multiplexes a vector of reduction digits over LANES
//                shared XPB lookup lanes and accumulates the returned table
//                words into one wide unsigned sum.
//  Ports       : clk_i        - clock, all state on rising edge
//                rst_ni       - synchronous active-low reset
//                in_valid_i   - digit vector valid
//                in_ready_o   - block idle and able to accept a vector
//                in_digits_i  - digit i at [i*DIG_W +: DIG_W]
//                lut_en_o     - lookup issue strobe (registered)
//                lut_pos_o    - per-lane table position (registered)
//                lut_digit_o  - per-lane table address (registered)
//                lut_data_i   - per-lane table word, one cycle after issue
//                out_valid_o  - sum valid, held until out_ready_i
//                out_ready_i  - consumer accepts the sum
//                out_sum_o    - accumulated sum (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module xpb_reduce_sched
   import xpb_sched_pkg::*;
#(
   parameter int WORD_W     = 1024,
   parameter int DIG_W      = 5,
   parameter int NUM_DIGITS = 8,
   parameter int LANES      = 2,
   parameter int POS_W      = $clog2(NUM_DIGITS),
   parameter int ACC_W      = calc_acc_w(WORD_W, NUM_DIGITS)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [NUM_DIGITS*DIG_W-1:0] in_digits_i,
   output logic                        lut_en_o,
   output logic [LANES*POS_W-1:0]      lut_pos_o,
   output logic [LANES*DIG_W-1:0]      lut_digit_o,
   input  logic [LANES*WORD_W-1:0]     lut_data_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [ACC_W-1:0]            out_sum_o
);

   localparam int C_NUM_BEATS = calc_beats(NUM_DIGITS, LANES);
   // One spare count so beat_q+1 never wraps on the final beat.
   localparam int C_BEAT_W    = $clog2(C_NUM_BEATS + 1);
   localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(C_NUM_BEATS - 1);

   state_e                        state_q, state_d;
   logic [C_BEAT_W-1:0]           beat_q, beat_d;
   logic [NUM_DIGITS*DIG_W-1:0]   digits_q, digits_d;
   logic [ACC_W-1:0]              acc_q, acc_d;
   logic                          lut_en_q, lut_en_d;
   logic [LANES*POS_W-1:0]        lut_pos_q, lut_pos_d;
   logic [LANES*DIG_W-1:0]        lut_digit_q, lut_digit_d;
   // live_q marks lanes of the beat currently on the lut outputs that map to
   // a real digit; data_live_q is the same mask delayed to line up with the
   // returned data. Clearing data_live_q on reset drops in-flight lookups.
   logic [LANES-1:0]              live_q, live_d;
   logic [LANES-1:0]              data_live_q, data_live_d;

   logic [C_BEAT_W-1:0]           w_next_beat;
   logic [NUM_DIGITS*DIG_W-1:0]   w_src_digits;
   logic [LANES*POS_W-1:0]        w_map_pos;
   logic [LANES*DIG_W-1:0]        w_map_digit;
   logic [LANES-1:0]              w_map_live;
   logic                          w_issue;
   logic [ACC_W-1:0]              w_sum;

   // The beat issued at the next edge: beat 0 straight from the input port
   // on accept, otherwise the following beat from the latched vector.
   assign w_next_beat  = (state_q == ST_IDLE) ? '0 : beat_q + 1'b1;
   assign w_src_digits = (state_q == ST_IDLE) ? in_digits_i : digits_q;

   always_comb begin
      w_map_pos   = '0;
      w_map_digit = '0;
      w_map_live  = '0;
      for (int l = 0; l < LANES; l++) begin
         if (lane_pos(int'(w_next_beat), l, LANES) < NUM_DIGITS) begin
            w_map_live[l]                    = 1'b1;
            w_map_pos[l*POS_W +: POS_W]      = POS_W'(lane_pos(int'(w_next_beat), l, LANES));
            w_map_digit[l*DIG_W +: DIG_W]    =
               w_src_digits[lane_pos(int'(w_next_beat), l, LANES)*DIG_W +: DIG_W];
         end
      end
   end

   xpb_lane_acc #(
      .WORD_W (WORD_W),
      .LANES  (LANES),
      .ACC_W  (ACC_W)
   ) u_lane_acc (
      .acc_i  (acc_q),
      .data_i (lut_data_i),
      .mask_i (data_live_q),
      .sum_o  (w_sum)
   );

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      digits_d    = digits_q;
      acc_d       = acc_q;
      lut_en_d    = 1'b0;
      lut_pos_d   = '0;
      lut_digit_d = '0;
      live_d      = '0;
      data_live_d = live_q;
      w_issue     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               digits_d = in_digits_i;
               acc_d    = '0;
               beat_d   = '0;
               w_issue  = 1'b1;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Data from the previous beat (zero-masked on beat 0).
            acc_d = w_sum;
            if (beat_q == C_LAST_BEAT) begin
               state_d = ST_DRAIN;
            end else begin
               beat_d  = w_next_beat;
               w_issue = 1'b1;
            end
         end
         ST_DRAIN: begin
            acc_d   = w_sum;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (w_issue) begin
         lut_en_d    = 1'b1;
         lut_pos_d   = w_map_pos;
         lut_digit_d = w_map_digit;
         live_d      = w_map_live;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         beat_q      <= '0;
         digits_q    <= '0;
         acc_q       <= '0;
         lut_en_q    <= 1'b0;
         lut_pos_q   <= '0;
         lut_digit_q <= '0;
         live_q      <= '0;
         data_live_q <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         digits_q    <= digits_d;
         acc_q       <= acc_d;
         lut_en_q    <= lut_en_d;
         lut_pos_q   <= lut_pos_d;
         lut_digit_q <= lut_digit_d;
         live_q      <= live_d;
         data_live_q <= data_live_d;
      end
   end

   assign in_ready_o  = rst_ni & (state_q == ST_IDLE);
   assign lut_en_o    = lut_en_q;
   assign lut_pos_o   = lut_pos_q;
   assign lut_digit_o = lut_digit_q;
   assign out_valid_o = (state_q == ST_DONE);
   assign out_sum_o   = acc_q;

endmodule : xpb_reduce_sched
`default_nettype wire

// File: doc/xpb_reduce_sched.md
# xpb_reduce_sched

Sequencer for the XPB reduction lookup stage of the modular squaring datapath. It accepts one vector of 5-bit reduction digits and time-multiplexes them over a small number of shared XPB lookup lanes, LANES digits per cycle. It accumulates the returned 1024-bit precomputed values into one wide sum. It sits between the upper-word digit extraction and the final compression adder, and trades XPB table area for latency.

## Interface
- WORD_W, 1024, width of one XPB table entry
- DIG_W, 5, width of one reduction digit (table address)
- NUM_DIGITS, 8, digits per operation; digit i addresses table position i
- LANES, 2, lookups issued per cycle
- POS_W, $clog2(NUM_DIGITS), width of a table position index
- ACC_W, WORD_W+$clog2(NUM_DIGITS+1), accumulator width; must never overflow

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  digit vector valid
- in_ready  out  1  block can accept a vector
- in_digits  in  NUM_DIGITS*DIG_W  digit i at bits [i*DIG_W +: DIG_W]
- lut_en  out  1  lookup issue strobe this cycle
- lut_pos  out  LANES*POS_W  per-lane table position
- lut_digit  out  LANES*DIG_W  per-lane table address
- lut_data  in  LANES*WORD_W  per-lane table value, valid exactly 1 cycle after issue
- out_valid  out  1  sum valid
- out_ready  in  1  consumer accepts sum
- out_sum  out  ACC_W  sum of all looked-up values

## Operation
- B = ceil(NUM_DIGITS/LANES) issue beats. Beat b, lane l maps to position p = b*LANES+l.
- States are IDLE, ISSUE, DRAIN and DONE.
- IDLE: in_ready=1. When in_valid is high, the block latches in_digits, clears the accumulator and the beat counter, and goes to ISSUE.
- ISSUE: lut_en=1. It drives p and digit p for every lane. A lane with p ≥ NUM_DIGITS drives lut_pos=0 and lut_digit=0, and its data is masked to zero. The beat counter increments each cycle. After beat B-1 the block goes to DRAIN.
- Accumulate: in each cycle following an issue cycle, acc += sum of the LANES masked lut_data words. This happens in ISSUE (from beat 1) and in DRAIN.
- DRAIN: performs the final accumulate, then goes to DONE.
- DONE: out_valid=1 and out_sum=acc, both held stable. When out_ready is high, the block goes to IDLE.
- in_ready=0 outside IDLE. There is no overlap between operations.
- Digit 0 is looked up like any other digit; the table returns 0 for it. The block does not skip zero digits.
- Arithmetic is unsigned and plain binary, with no modular reduction here. With ACC_W as defined, the sum of NUM_DIGITS values below 2^WORD_W cannot overflow.
- Reset: rst_n low at any clock edge forces IDLE, clears acc and the counter, and discards any in-flight lookup. Returned data for a discarded lookup is ignored.
- Reset values: in_ready=1 once rst_n is high (0 while rst_n is low), lut_en=0, lut_pos=0, lut_digit=0, out_valid=0, out_sum=0.

## Timing
- The accept edge is T0. Beat b is issued in cycle T0+b, and its data is added at the end of cycle T0+b+1.
- out_valid first rises in cycle T0+B+1. With the default parameters (B=4), that is 5 cycles after accept.
- The earliest next accept is 1 cycle after the out handshake, because IDLE is always visited.
- lut_pos, lut_digit and lut_en are registered and change only on clock edges.
- out_sum is registered. It must not change while out_valid=1 and out_ready=0.

## Structure
- The package xpb_sched_pkg holds:
  - the state enum;
  - the B and ACC_W derivation functions;
  - the lane-to-position mapping function.
- Sub-module xpb_lane_acc: a combinational (LANES+1)-input adder of ACC_W bits, with per-lane zero masking. The register sits in the parent.
- The XPB tables and the position mux stay outside this block.

## Test plan
Use a 1-cycle-latency table model that returns value = (pos+1)*2^DIG_W + digit, and digit 0 returns 0.
1. All digits zero, with defaults → out_valid at T0+5 and out_sum = 0. lut_en must be high for exactly 4 cycles.
2. Digits i = i+1 (1..8) → out_sum = Σ ((i+1)*32 + (i+1)) = 36*33 = 1188. lut_pos must follow the beat sequence {0,1},{2,3},{4,5},{6,7}.
3. Replace the model with one returning 2^1024-1 for every nonzero digit, and set all digits to 31 → out_sum = 8*(2^1024-1), with no overflow (ACC_W=1028).
4. With NUM_DIGITS=5 and LANES=2, digits 1..5 → B=3, and the last beat drives lane 1 with pos=0 and digit=0. That lane is masked, so out_sum = Σ over i=0..4 of ((i+1)*32 + (i+1)) = 15*33 = 495. out_valid rises at T0+4.
5. Hold out_ready low for 10 cycles in DONE → out_valid and out_sum stay stable, in_ready stays 0, and in_valid pulses are ignored. The out handshake is followed by in_ready=1 on the next cycle.
6. Assert rst_n low during ISSUE beat 2 → on the next cycle all outputs take their reset values. A new vector is then accepted and produces the correct sum, with no stale data accumulated.
